// File: rtl/srff_bank_pkg.sv
// Shared definitions for the SR flag bank arbiter.
//   - SR command encodings, ordered {s,r}
//   - default N / W / IW parameter values
//   - sr_decode: maps an {s,r} command and the current bit value to the
//     next bit value plus a legality flag
package srff_bank_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  localparam int N_DEF  = 4;
  localparam int W_DEF  = 8;
  localparam int IW_DEF = 3;

  typedef struct packed {
    logic nxt;    // next value of the addressed bit
    logic legal;  // 0 for s=r=1
  } sr_dec_t;

  // s=r=1 keeps the current value so the bank never goes unknown.
  function automatic sr_dec_t sr_decode(input logic [1:0] sr, input logic cur);
    sr_dec_t d;
    d.nxt   = cur;
    d.legal = 1'b1;
    case (sr)
      CMD_CLR: d.nxt   = 1'b0;
      CMD_SET: d.nxt   = 1'b1;
      CMD_ILL: d.legal = 1'b0;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/srff_bank_arb_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   elig      [N]       eligible requesters
//   ptr       [log2 N]  requester with highest priority this cycle
//   win       [N]       one-hot winner (all zero when nothing eligible)
//   win_valid           some requester won
module rr_arbiter
  import srff_bank_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          win_valid
);

  int best_dist;
  int best_j;

  // Priority is the distance of a requester from ptr going upward with
  // wrap; the eligible requester with the smallest distance wins.
  always_comb begin
    best_dist = N;
    best_j    = 0;
    for (int j = 0; j < N; j++) begin
      if (elig[j] && (((j + N - int'(ptr)) % N) < best_dist)) begin
        best_dist = (j + N - int'(ptr)) % N;
        best_j    = j;
      end
    end
    win_valid = (best_dist < N);
    win       = '0;
    for (int j = 0; j < N; j++) begin
      win[j] = win_valid && (j == best_j);
    end
  end

endmodule

// File: rtl/srff_bank_arb.sv
// srff_bank_arb: bank of W SR flag bits shared by N requesters.
// One requester per clock is granted round-robin; its {s,r} command is
// applied to flag bit idx_i on the same edge that raises its grant.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req   [N]             request, held until the matching gnt is seen
//   cmd_s, cmd_r [N]      SR set / reset inputs per requester
//   idx   [N*IW]          target bit, requester i at [i*IW +: IW]
//   gnt   [N]             registered one-hot one-cycle grant
//   q, qb [W]             flag bank and its complement
//   busy                  some request lost arbitration at the last edge
// Optional (macro SRFF_BANK_ERR_EN):
//   err                   sticky: granted s=r=1 or granted idx >= W
//   err_src [log2 N]      requester that raised the first error
module srff_bank_arb
  import srff_bank_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int IW = IW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    cmd_s,
  input  logic [N-1:0]    cmd_r,
  input  logic [N*IW-1:0] idx,
  output logic [N-1:0]    gnt,
  output logic [W-1:0]    q,
  output logic [W-1:0]    qb,
  output logic            busy
`ifdef SRFF_BANK_ERR_EN
  ,
  output logic                 err,
  output logic [$clog2(N)-1:0] err_src
`endif
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [N-1:0]  elig;
  logic [N-1:0]  win;
  logic          win_valid;
  logic [PW-1:0] win_id;
  logic [IW-1:0] win_idx;
  logic [1:0]    win_sr;
  logic          in_range;
  sr_dec_t       dec;
  logic [W-1:0]  q_nxt;
  logic          busy_nxt;

  // A requester still showing req while its grant is high is dropping it;
  // masking it here prevents granting the same transaction twice.
  assign elig = req & ~gnt;

  rr_arbiter #(.N(N)) u_arb (
    .elig      (elig),
    .ptr       (ptr),
    .win       (win),
    .win_valid (win_valid)
  );

  always_comb begin
    win_id  = '0;
    win_idx = '0;
    win_sr  = CMD_HOLD;
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        win_id  = PW'(i);
        win_idx = idx[i*IW +: IW];
        win_sr  = {cmd_s[i], cmd_r[i]};
      end
    end
  end

  assign in_range = (int'(win_idx) < W);
  assign ptr_nxt  = (int'(win_id) == N - 1) ? '0 : win_id + PW'(1);
  assign busy_nxt = ($countones(elig) >= 2);

  // Only the addressed bit can change; an illegal command holds it.
  always_comb begin
    dec   = sr_decode(win_sr, 1'b0);
    q_nxt = q;
    for (int b = 0; b < W; b++) begin
      if (win_valid && in_range && (int'(win_idx) == b)) begin
        dec      = sr_decode(win_sr, q[b]);
        q_nxt[b] = dec.legal ? dec.nxt : q[b];
      end
    end
  end

  // ---- register stage: grant, pointer, busy and flag bank ----
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      gnt  <= '0;
      busy <= 1'b0;
      ptr  <= '0;
    end else begin
      q    <= q_nxt;
      gnt  <= win;
      busy <= busy_nxt;
      if (win_valid) begin
        ptr <= ptr_nxt;
      end
    end
  end

  assign qb = ~q;

`ifdef SRFF_BANK_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_src <= '0;
    end else if (win_valid && (!dec.legal || !in_range)) begin
      err <= 1'b1;
      if (!err) begin
        err_src <= win_id;
      end
    end
  end
`endif

endmodule

// File: tb/tb_srff_bank_arb.sv
module tb_srff_bank_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, cmd_s, cmd_r, gnt;
  logic [N*IW-1:0] idx;
  logic [W-1:0]    q, qb;
  logic            busy;
`ifdef SRFF_BANK_ERR_EN
  logic            err;
  logic [1:0]      err_src;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  srff_bank_arb #(.N(N), .W(W), .IW(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .cmd_s (cmd_s),
    .cmd_r (cmd_r),
    .idx   (idx),
    .gnt   (gnt),
    .q     (q),
    .qb    (qb),
    .busy  (busy)
`ifdef SRFF_BANK_ERR_EN
    ,
    .err     (err),
    .err_src (err_src)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state of the bank described directly from the rules.
  logic [W-1:0] m_q, m_qb;
  logic [N-1:0] m_gnt;
  logic         m_busy;
  int           m_ptr;
  logic         m_err;
  int           m_err_src;

  always @(posedge clk) begin : model
    int cnt, winner, t;
    if (rst) begin
      m_q = '0; m_gnt = '0; m_busy = 1'b0; m_ptr = 0;
      m_err = 1'b0; m_err_src = 0;
    end else begin
      cnt = 0;
      winner = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req[j] && !m_gnt[j]) begin
          cnt++;
          if (winner < 0) winner = j;
        end
      end
      m_gnt  = '0;
      m_busy = (cnt >= 2);
      if (winner >= 0) begin
        m_gnt[winner] = 1'b1;
        m_ptr = (winner + 1) % N;
        t = int'(idx[winner*IW +: IW]);
        if (t < W) begin
          if (cmd_s[winner] && !cmd_r[winner]) m_q[t] = 1'b1;
          else if (!cmd_s[winner] && cmd_r[winner]) m_q[t] = 1'b0;
        end
        if ((t >= W) || (cmd_s[winner] && cmd_r[winner])) begin
          if (!m_err) m_err_src = winner;
          m_err = 1'b1;
        end
      end
    end
    m_qb = ~m_q;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", gnt, m_gnt);
      chk("q", q, m_q);
      chk("qb", qb, m_qb);
      chk("busy", busy, m_busy);
`ifdef SRFF_BANK_ERR_EN
      chk("err", err, m_err);
      chk("err_src", err_src, m_err_src);
`endif
    end
  end

  // One complete handshake for requester i; returns at the negedge where
  // its grant is visible, with req already dropped.
  task automatic xact(input int i, input bit s, input bit r, input int ix);
    int t;
    @(negedge clk);
    req[i] = 1'b1; cmd_s[i] = s; cmd_r[i] = r; idx[i*IW +: IW] = IW'(ix);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!gnt[i] && t < 20);
    chk("xact_gnt", gnt[i], 1);
    req[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; req = '0; cmd_s = '0; cmd_r = '0; idx = '0;
    // Reset, then idle
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_q", q, 8'h00);
      chk("idle_qb", qb, 8'hFF);
      chk("idle_gnt", gnt, 0);
      chk("idle_busy", busy, 0);
    end

    // Single set / clear
    xact(2, 1'b1, 1'b0, 5);
    chk("set_gnt", gnt, 4'b0100);
    chk("set_q", q, 8'h20);
    @(negedge clk);
    chk("set_gnt_pulse", gnt, 0);
    xact(2, 1'b0, 1'b1, 5);
    chk("clr_q", q, 8'h00);

    // Round-robin fairness from ptr=0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b1; cmd_s[i] = 1'b1; cmd_r[i] = 1'b0; idx[i*IW +: IW] = IW'(i);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rr_gnt", gnt, 1 << c);
      chk("rr_busy", busy, c < 3);
      req = req & ~gnt;
    end
    chk("rr_q", q, 8'h0F);

    // Illegal command and out-of-range index
    xact(1, 1'b1, 1'b1, 3);
    chk("ill_q", q, 8'h0F);
`ifdef SRFF_BANK_ERR_EN
    chk("ill_err", err, 1);
    chk("ill_err_src", err_src, 1);
`endif
    xact(1, 1'b1, 1'b0, 9);
    chk("oor_q", q, 8'h0F);
`ifdef SRFF_BANK_ERR_EN
    chk("oor_err", err, 1);
    chk("oor_err_src", err_src, 1);
`endif

    // Build q=AA, then reset with three requests pending
    xact(0, 1'b0, 1'b1, 0);
    xact(0, 1'b0, 1'b1, 2);
    xact(0, 1'b1, 1'b0, 5);
    xact(0, 1'b1, 1'b0, 7);
    chk("aa_q", q, 8'hAA);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i < N; i++) begin
      req[i] = 1'b1; cmd_s[i] = 1'b1; cmd_r[i] = 1'b0; idx[i*IW +: IW] = IW'(i + 3);
    end
    @(negedge clk);
    chk("mrst_q", q, 8'h00);
    chk("mrst_gnt", gnt, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b0;
    req[0] = 1'b1; cmd_s[0] = 1'b1; cmd_r[0] = 1'b0; idx[0 +: IW] = IW'(7);
    @(negedge clk);
    chk("mrst_first_gnt", gnt, 4'b0001);
    req = req & ~gnt;
    t = 0;
    while (req != '0 && t < 10) begin
      @(negedge clk);
      req = req & ~gnt;
      t++;
    end
    chk("drain_done", t < 10, 1);
    chk("drain_q", q, 8'hF0);

    // Withdrawn request: requester 3 drops req just before its turn
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b1; cmd_s[i] = 1'b0; cmd_r[i] = 1'b0;
    end
    req[3] = 1'b1; cmd_s[3] = 1'b1; cmd_r[3] = 1'b0; idx[3*IW +: IW] = IW'(0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("wd_gnt3", gnt[3], 0);
      req = req & ~gnt;
      if (c == 2) req[3] = 1'b0;
    end
    chk("wd_q", q, 8'hF0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/srff_bank_arb.md
Name: srff_bank_arb

Overview:
- Bank of W SR-style flag bits shared between N requesters; each requester submits one set/clear/hold command per transaction via a req/gnt handshake.
- A round-robin arbiter grants at most one requester per clock and applies the winner's SR command to the addressed flag bit.
- Sits between control FSMs and the shared status-flag register that drives downstream q/qb consumers.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, number of flag bits in the bank
- IW, 3, index width per requester; must satisfy 2**IW >= W

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  N  request per requester; held high until its gnt is seen
- cmd_s  input  N  SR "set" input per requester
- cmd_r  input  N  SR "reset" input per requester
- idx  input  N*IW  target bit per requester; requester i uses bits [i*IW +: IW]
- gnt  output  N  registered one-hot grant; one-cycle pulse
- q  output  W  flag bank state
- qb  output  W  always ~q
- busy  output  1  registered; high if any request went ungranted at the last edge

Behaviour:
- Reset, applied at a clock edge with rst=1:
  - q=0, gnt=0, busy=0, round-robin pointer ptr=0.
  - rst overrides every request in the same cycle; no command is applied.
  - Reset mid-transaction drops all pending requests. Requesters must re-present them.
- Eligibility: requester i is eligible when req[i]=1 and gnt[i]=0. The gnt[i]=0 condition prevents a double grant in the cycle the requester is still dropping req.
- Arbitration, combinational:
  - Search the eligible set starting at ptr, ascending with wrap at N.
  - The first eligible requester is the winner.
  - No eligible requester means an idle cycle: gnt=0 and ptr unchanged.
- On each edge with a winner i:
  - gnt <= one-hot(i).
  - ptr <= (i+1) mod N.
  - The command is applied to bit b = idx_i in the same edge, so q is visible alongside gnt. Single-edge latency from the req edge to gnt/q update.
- SR command table on q[b]:
  - s=0, r=0: hold; granted, no change.
  - s=0, r=1: clear to 0.
  - s=1, r=0: set to 1.
  - s=1, r=1: illegal; q[b] is unchanged (never X); handshake completes normally.
- idx_i >= W: grant issued, no bit modified.
- Only one bit changes per cycle. Bits not addressed by the winner hold.
- busy <= 1 when the eligible count is >= 2 at the edge, i.e. some requester lost; otherwise busy <= 0.
- A requester whose req drops before its grant is simply skipped (request withdrawn); no error.
- Starvation bound: any continuously eligible requester is granted within N cycles.

Optional Feature:
- Macro: SRFF_BANK_ERR_EN
- With the macro defined, extra ports:
  - err  output  1: sticky, set on a granted s=r=1 command or a granted idx >= W; cleared only by rst.
  - err_src  output  clog2(N): requester id of the first error, captured only while err=0; reset 0.
- q behaviour is identical with or without the macro.
- Without the macro: no err ports; illegal commands are silently treated as hold.

Decomposition:
- Shared package srff_bank_pkg holds:
  - command encoding constants: CMD_HOLD=2'b00, CMD_CLR=2'b01, CMD_SET=2'b10, CMD_ILL=2'b11, ordered {s,r}
  - the default N/W/IW values
  - a function decoding {s,r} to next-bit value plus a legal flag
- One sub-module, rr_arbiter: parameter N; inputs elig[N] and ptr; output one-hot win[N] and win_valid; purely combinational.
- Pointer, grant and flag registers live in srff_bank_arb.

Test Plan:
- Reset, then idle:
  - Assert rst for 2 cycles, then hold req=0 for 5 cycles.
  - Expect q=8'h00, qb=8'hFF, gnt=0 and busy=0 throughout.
- Single set/clear:
  - Requester 2 sends s=1, r=0, idx=5.
  - Expect gnt=4'b0100 for exactly one cycle and q=8'h20.
  - Then s=0, r=1, idx=5: expect q=8'h00.
- Round-robin fairness:
  - All 4 requesters hold req continuously with set commands to idx 0..3.
  - Expect grants in order 0,1,2,3 on consecutive cycles; busy=1 for the first 3 grants.
  - Expect q=8'h0F after 4 grants, and no requester granted twice before all are served.
- Illegal and out-of-range:
  - Requester 1 sends s=1, r=1 to idx=3 while q[3]=1; expect q[3] stays 1 and gnt[1] pulses.
  - Then idx=9 with W=8; expect q unchanged.
  - With SRFF_BANK_ERR_EN defined: err=1 and err_src=1 after the first case, unchanged by the second.
- Reset mid-operation:
  - With q=8'hAA and 3 requests pending, assert rst for one edge.
  - Expect q=0, gnt=0 and ptr=0; requester 0 wins the next grant.
- Withdrawn request:
  - Requester 3 raises req, then drops it the cycle before its turn.
  - Expect gnt[3] never asserts and q is untouched for its idx.
